// File: rtl/regfile_2r1w_if.sv
// Register file access bundle: two read ports, one write port, init status.
// The decode/writeback side uses master; the register file uses slave.
interface regfile_2r1w_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              init_busy;
    logic              rd_en_a;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic              rd_valid_a;
    logic              rd_en_b;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              rd_valid_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        output wr_en, wr_addr, wr_data,
        input  rd_data_a, rd_valid_a, rd_data_b, rd_valid_b,
        input  init_busy
    );

    modport slave (
        input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        input  wr_en, wr_addr, wr_data,
        output rd_data_a, rd_valid_a, rd_data_b, rd_valid_b,
        output init_busy
    );
endinterface

// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with registered reads, optional
// write bypass, optional hardwired zero entry and a reset clear sweep.
module regfile_2r1w #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic           clk,
    input logic           rst,
    regfile_2r1w_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
    logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;
    logic              rd_valid_a_q, rd_valid_a_d;
    logic              rd_valid_b_q, rd_valid_b_d;

    logic              wr_drop;
    logic              wr_live;
    logic [DATA_W-1:0] rd_val_a;
    logic [DATA_W-1:0] rd_val_b;

    assign wr_drop = (ZERO_REG != 0) && (bus.wr_addr == '0);
    assign wr_live = (state_q == READY) && bus.wr_en && !wr_drop;

    // Port A read value: zero entry beats bypass, bypass beats storage.
    always_comb begin
        rd_val_a = mem[bus.rd_addr_a];
        if ((BYPASS != 0) && wr_live && (bus.wr_addr == bus.rd_addr_a))
            rd_val_a = bus.wr_data;
        if ((ZERO_REG != 0) && (bus.rd_addr_a == '0))
            rd_val_a = '0;
    end

    // Port B read value, same priority as port A.
    always_comb begin
        rd_val_b = mem[bus.rd_addr_b];
        if ((BYPASS != 0) && wr_live && (bus.wr_addr == bus.rd_addr_b))
            rd_val_b = bus.wr_data;
        if ((ZERO_REG != 0) && (bus.rd_addr_b == '0))
            rd_val_b = '0;
    end

    // Next state, clear sweep write, and read port updates.
    always_comb begin
        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        mem_we       = 1'b0;
        mem_waddr    = bus.wr_addr;
        mem_wdata    = bus.wr_data;
        rd_data_a_d  = rd_data_a_q;
        rd_data_b_d  = rd_data_b_q;
        rd_valid_a_d = 1'b0;
        rd_valid_b_d = 1'b0;
        unique case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = '0;
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                if (&clr_ptr_q)
                    state_d = READY;
            end
            READY: begin
                mem_we = wr_live;
                if (bus.rd_en_a) begin
                    rd_valid_a_d = 1'b1;
                    rd_data_a_d  = rd_val_a;
                end
                if (bus.rd_en_b) begin
                    rd_valid_b_d = 1'b1;
                    rd_data_b_d  = rd_val_b;
                end
            end
        endcase
    end

    // Control and read-port registers; reset restarts the sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLEAR;
            clr_ptr_q    <= '0;
            rd_data_a_q  <= '0;
            rd_data_b_q  <= '0;
            rd_valid_a_q <= 1'b0;
            rd_valid_b_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            rd_data_a_q  <= rd_data_a_d;
            rd_data_b_q  <= rd_data_b_d;
            rd_valid_a_q <= rd_valid_a_d;
            rd_valid_b_q <= rd_valid_b_d;
        end
    end

    // Storage array; only the sweep or a live write touches it.
    always_ff @(posedge clk) begin
        if (!rst && mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    assign bus.init_busy  = (state_q == CLEAR);
    assign bus.rd_data_a  = rd_data_a_q;
    assign bus.rd_data_b  = rd_data_b_q;
    assign bus.rd_valid_a = rd_valid_a_q;
    assign bus.rd_valid_b = rd_valid_b_q;
endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench: one DUT with zero-reg+bypass, one with neither,
// driven identically and compared against an array-based model.
module tb_regfile_2r1w;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          ren_a, ren_b, we;
    logic [AW-1:0] ra, rb, wa;
    logic [DW-1:0] wd;

    regfile_2r1w_if #(.DATA_W(DW), .ADDR_W(AW)) bus_on ();
    regfile_2r1w_if #(.DATA_W(DW), .ADDR_W(AW)) bus_off ();

    assign bus_on.rd_en_a   = ren_a;
    assign bus_on.rd_addr_a = ra;
    assign bus_on.rd_en_b   = ren_b;
    assign bus_on.rd_addr_b = rb;
    assign bus_on.wr_en     = we;
    assign bus_on.wr_addr   = wa;
    assign bus_on.wr_data   = wd;

    assign bus_off.rd_en_a   = ren_a;
    assign bus_off.rd_addr_a = ra;
    assign bus_off.rd_en_b   = ren_b;
    assign bus_off.rd_addr_b = rb;
    assign bus_off.wr_en     = we;
    assign bus_off.wr_addr   = wa;
    assign bus_off.wr_data   = wd;

    regfile_2r1w #(
        .DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)
    ) dut_on (
        .clk(clk), .rst(rst), .bus(bus_on.slave)
    );

    regfile_2r1w #(
        .DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(0)
    ) dut_off (
        .clk(clk), .rst(rst), .bus(bus_off.slave)
    );

    int checks = 0;
    int errors = 0;

    // model: k=0 -> zero-reg+bypass, k=1 -> plain
    logic [DW-1:0] mm [2][DEPTH];
    logic [DW-1:0] sb [4][$];
    logic [DW-1:0] last [4];
    int            busy_cnt = 0;
    bit            armed = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_read(input int k,
                                               input logic [AW-1:0] a);
        bit zr = (k == 0);
        bit bp = (k == 0);
        if (zr && a == 0) return '0;
        if (bp && we && wa == a && !(zr && wa == 0)) return wd;
        return mm[k][a];
    endfunction

    // Apply one cycle of inputs; update the model at the clock edge.
    task automatic step(input logic r,
                        input logic ea, input logic [AW-1:0] aa,
                        input logic eb, input logic [AW-1:0] ab,
                        input logic ew, input logic [AW-1:0] aw,
                        input logic [DW-1:0] dw);
        rst = r; ren_a = ea; ra = aa; ren_b = eb; rb = ab;
        we = ew; wa = aw; wd = dw;
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < DEPTH; i++) mm[k][i] = '0;
            for (int i = 0; i < 4; i++) begin
                sb[i].delete();
                last[i] = '0;
            end
            busy_cnt = DEPTH;
            armed = 1'b1;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (ea) sb[2*k].push_back(ref_read(k, aa));
                if (eb) sb[2*k+1].push_back(ref_read(k, ab));
            end
            for (int k = 0; k < 2; k++)
                if (ew && !(k == 0 && aw == 0)) mm[k][aw] = dw;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: pop on valid, otherwise data must hold the last value.
    logic          mv [4];
    logic [DW-1:0] md [4];
    always @(negedge clk) begin
        if (armed) begin
            mv = '{bus_on.rd_valid_a, bus_on.rd_valid_b,
                   bus_off.rd_valid_a, bus_off.rd_valid_b};
            md = '{bus_on.rd_data_a, bus_on.rd_data_b,
                   bus_off.rd_data_a, bus_off.rd_data_b};
            for (int i = 0; i < 4; i++) begin
                if (mv[i] === 1'b1) begin
                    if (sb[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid_%0d: got 1, expected 0", i);
                    end else begin
                        logic [DW-1:0] e;
                        e = sb[i].pop_front();
                        check($sformatf("rd_data_%0d", i), md[i], e);
                        last[i] = e;
                    end
                end else begin
                    check($sformatf("rd_valid_%0d", i), {31'd0, mv[i]}, '0);
                    check($sformatf("hold_%0d", i), md[i], last[i]);
                end
                check($sformatf("pending_%0d", i), sb[i].size(), '0);
            end
            check("init_busy_on", {31'd0, bus_on.init_busy},
                  {31'd0, busy_cnt > 0});
            check("init_busy_off", {31'd0, bus_off.init_busy},
                  {31'd0, busy_cnt > 0});
        end
    end

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
        return AW'($urandom);
    endfunction

    initial begin
        // reset 2 cycles, then sweep with ignored writes/reads
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++)
            step(0, 1, AW'(i), 1, AW'(i), 1, AW'(i), 32'hCAFE0000 + i);
        for (int i = 0; i < DEPTH; i++)
            step(0, 1, AW'(i), 1, AW'(DEPTH - 1 - i), 0, 0, 0);

        // write then dual read
        step(0, 0, 0, 0, 0, 1, 7, 32'hDEADBEEF);
        step(0, 1, 7, 1, 7, 0, 0, 0);

        // bypass on address 5
        step(0, 0, 0, 0, 0, 1, 5, 32'h11);
        step(0, 1, 5, 0, 0, 1, 5, 32'h22);
        step(0, 1, 5, 1, 5, 0, 0, 0);

        // zero register
        step(0, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF);
        step(0, 1, 0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 1, 0, 32'h12345678);
        step(0, 1, 0, 0, 0, 0, 0, 0);

        // reset mid-sweep with writes issued during the sweep
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            step(0, 0, 0, 0, 0, 1, 9, 32'h99);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++)
            step(0, 1, 9, 0, 0, 1, 9, 32'hBAD0 + i);
        step(0, 1, 9, 1, 10, 0, 0, 0);

        // hold: read 3, then idle port A while rewriting 3
        step(0, 0, 0, 0, 0, 1, 3, 32'hA5);
        step(0, 1, 3, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 0, 0, 1, 3, 32'h5A);
        step(0, 1, 3, 0, 0, 0, 0, 0);

        // randomized traffic with rare resets
        for (int n = 0; n < 3000; n++) begin
            logic [DW-1:0] d;
            d = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
            step($urandom_range(0, 599) == 0,
                 1'($urandom_range(0, 1)), rnd_addr(),
                 1'($urandom_range(0, 1)), rnd_addr(),
                 1'($urandom_range(0, 2) != 0), rnd_addr(), d);
        end
        idle(3);

        for (int i = 0; i < 4; i++)
            check($sformatf("drain_%0d", i), sb[i].size(), '0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
